// File: rtl/alu_operand_fetch.sv
// rtl/alu_operand_fetch.sv - operand fetch stage with busy-bit scoreboard feeding the pipelined ALU
// Optional write-through bypass enabled by defining FETCH_BYPASS_EN.
module alu_operand_fetch #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [AW-1:0] iss_rs1,
  input  logic [AW-1:0] iss_rs2,
  input  logic [AW-1:0] iss_rd,
  input  logic [2:0]    iss_S,
  input  logic          iss_Cin,
  output logic [DW-1:0] abus,
  output logic [DW-1:0] bbus,
  output logic [2:0]    S,
  output logic          Cin,
  output logic          out_valid,
  output logic [AW-1:0] out_rd,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  localparam int NR = 1 << AW;

  logic [DW-1:0] rf [NR];
  logic [NR-1:0] busy;
  logic [NR-1:0] busy_nx;
  logic          byp1, byp2, bypd;
  logic [DW-1:0] rd1, rd2;
  logic          accept;

`ifdef FETCH_BYPASS_EN
  // A write to r0 is dropped, so it must not forward either.
  assign byp1 = wr_en && (wr_addr == iss_rs1) && (wr_addr != '0);
  assign byp2 = wr_en && (wr_addr == iss_rs2) && (wr_addr != '0);
  assign bypd = wr_en && (wr_addr == iss_rd)  && (wr_addr != '0);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign bypd = 1'b0;
`endif

  always_comb begin
    rd1 = rf[iss_rs1];
    if (iss_rs1 == '0)
      rd1 = '0;
    else if (byp1)
      rd1 = wr_data;
  end

  always_comb begin
    rd2 = rf[iss_rs2];
    if (iss_rs2 == '0)
      rd2 = '0;
    else if (byp2)
      rd2 = wr_data;
  end

  assign iss_ready = (!busy[iss_rs1] || byp1) &&
                     (!busy[iss_rs2] || byp2) &&
                     (!busy[iss_rd]  || bypd);
  assign accept = iss_valid && iss_ready;

  // Set is applied after clear so an issue to the writeback register keeps it busy.
  always_comb begin
    busy_nx = busy;
    if (wr_en)
      busy_nx[wr_addr] = 1'b0;
    if (accept && (iss_rd != '0))
      busy_nx[iss_rd] = 1'b1;
    busy_nx[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++)
        rf[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      rf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      abus      <= '0;
      bbus      <= '0;
      S         <= '0;
      Cin       <= 1'b0;
      out_rd    <= '0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        abus   <= rd1;
        bbus   <= rd2;
        S      <= iss_S;
        Cin    <= iss_Cin;
        out_rd <= iss_rd;
      end
    end
  end

endmodule

// File: doc/alu_operand_fetch.md
# alu_operand_fetch

Operand-fetch stage that sits directly upstream of the pipelined ALU. It holds a 32-entry register file and accepts issued operations with source and destination register numbers. It drives the ALU's `abus`, `bbus`, `S` and `Cin` from a registered output stage, and accepts ALU results back through a write port. A busy-bit scoreboard stalls issue while a source or destination register has a result still in flight through the ALU.

## Interface
- `DW`, default 32: data width; matches the ALU `abus`/`bbus`/`dbus` width.
- `AW`, default 5: register address width; the register file has 2^AW entries.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `iss_valid` in 1: an operation is presented.
- `iss_ready` out 1: the operation is accepted on this edge when `iss_valid` is also high. This output is combinational.
- `iss_rs1` in AW: source register for `abus`.
- `iss_rs2` in AW: source register for `bbus`.
- `iss_rd` in AW: destination register.
- `iss_S` in 3: ALU function select (000 xor, 001 xnor, 010 add, 011 sub, 100 or, 101 nor, 110 and).
- `iss_Cin` in 1: ALU carry-in.
- `abus` out DW: registered operand A.
- `bbus` out DW: registered operand B.
- `S` out 3: registered function select.
- `Cin` out 1: registered carry-in.
- `out_valid` out 1: registered; the outputs hold a real operation this cycle.
- `out_rd` out AW: registered destination, carried alongside the operation to writeback.
- `wr_en` in 1: writeback strobe from the result stage.
- `wr_addr` in AW: writeback destination.
- `wr_data` in DW: writeback value, taken from the ALU `dbus`.

## Operation
- **Register file**
  - 2^AW x DW storage.
  - Register 0 always reads 0.
  - Writes to register 0 are ignored.
- **Scoreboard**
  - One busy bit per register; busy[0] is always 0.
  - An accepted issue with rd≠0 sets busy[rd].
  - `wr_en` clears busy[wr_addr].
  - When both happen to the same register on the same edge, the set wins.
- **Hazard rule.** A register r is clear when busy[r]==0, or when the bypass is compiled in and `wr_en` is high with `wr_addr`==r. `iss_ready` = clear(rs1) && clear(rs2) && clear(rd).
- **Accept** (`iss_valid && iss_ready` at a rising edge):
  - Capture the operand reads into `abus` and `bbus`.
  - Capture `iss_S` into `S`, `iss_Cin` into `Cin` and `iss_rd` into `out_rd`.
  - Set `out_valid`=1.
- **No accept:**
  - `out_valid`=0 (a bubble).
  - `abus`, `bbus`, `S`, `Cin` and `out_rd` hold their previous values.
  - The downstream stage ignores results from bubbles.
- **Writes.** Writes occur on the rising edge regardless of the issue state.
- **Width.** There are no width conversions; all data paths are exactly DW.

## Timing
- **Reset** (asynchronous, while `rst_n`=0):
  - Every register-file entry and every busy bit is 0.
  - `out_valid`, `abus`, `bbus`, `S`, `Cin` and `out_rd` are all 0.
- **Latency.**
  - The issue is accepted at edge N, and the outputs are valid after edge N.
  - The ALU captures them at edge N+1, and `dbus` is valid after edge N+2.
- **Back-to-back issue.** Independent operations issue every cycle.
- **Dependent issue.** A dependent operation stalls until writeback of its producer.
- **Reset mid-operation.** All in-flight busy bits are dropped. A stale `wr_en` arriving after reset still writes data, and clearing an already-clear bit has no effect.
- **Stall.** During a stall the upstream must hold `iss_*` stable until accept.

## Configuration
- `FETCH_BYPASS_EN`
  - **Defined:**
    - A read of register r in the same cycle as `wr_en` to r returns `wr_data` (write-through).
    - The hazard rule treats that register as clear, so a dependent operation issues on the writeback edge itself.
  - **Undefined:**
    - A read returns the stored value only, and the hazard rule uses busy bits alone.
    - A dependent operation issues at the earliest one edge after its writeback.
    - `iss_ready` has no combinational path from `wr_*`.

## Test plan
- **Reset check.** Assert `rst_n`=0 mid-run, then release. Require `out_valid`=0, `abus`=`bbus`=0 and `iss_ready`=1. An issue of r1+r2 must then produce `abus`=`bbus`=0.
- **Write then read.** Write 0x7FFFFFFF to r3 and 0x00000001 to r4, then issue rs1=3, rs2=4, S=010, Cin=0, rd=5. Require `abus`=0x7FFFFFFF, `bbus`=0x00000001, `S`=010 and `out_rd`=5.
- **RAW stall.** Issue rd=5, then issue rs1=5. Require `iss_ready`=0 and `out_valid`=0 until the writeback to r5 of 0x80000000.
  - With the bypass: accept occurs on the writeback edge with `abus`=0x80000000.
  - Without the bypass: accept occurs one edge later.
- **Register 0.** Write 0xFFFFFFFF to r0, then issue rs1=0, rd=0. Require `abus`=0, no stall, and busy[0] never set.
- **Back-to-back independent issue.** Issue four independent operations back to back. Require `out_valid`=1 on four consecutive cycles, with the outputs matching each issue in order.
- **Set-wins collision.** Write to r6 on the same edge as accepting an issue with rd=6 (bypass defined). Require busy[6] to remain set, and a following rs1=6 issue to stall.
